// File: rtl/systolic_array_pkg.sv
// Shared types and constants for the SPAD-fed systolic array and its job scheduler.
// No ports; this package holds the result word type, the scheduler FSM encoding
// and the scheduler's default drain and watchdog limits.
package systolic_array_pkg;

    localparam int SA_N   = 4;
    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_RUN,
        S_DRAIN,
        S_EMIT,
        S_FIN,
        S_ABORT
    } sched_state_t;

    // Drain covers the array's skewed output pipeline: two passes of the lane count.
    localparam int SCHED_DRAIN   = 2 * SA_N;
    localparam int SCHED_TMO     = 64;
    // Window in which the array must acknowledge a start by raising busy.
    localparam int SCHED_WAIT_HI = 4;

endpackage

// File: rtl/sa_job_sched_watchdog.sv
// Loadable down-counter that flags the final cycle of a timing window.
// Ports: clk, n_rst (async, active-high), i_clear, i_load/i_limit, i_en, o_expired.
// o_expired is high during the last enabled cycle of a window loaded with i_limit.
module sa_watchdog #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [CW-1:0] i_limit,
    input  logic          i_en,
    output logic          o_expired
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_limit;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A window of L cycles counts L..1; the cycle showing 1 is the last one allowed.
    assign o_expired = i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/sa_job_sched.sv
// Job scheduler: issues one start per tile to top_pd, waits busy+drain, emits the result.
// Latency: start 1 cycle after accept; result valid DRAIN+1 cycles after busy falls.
// Backpressure: result held on res_*_o until res_ready_i; no new tile starts meanwhile.
// Ports: job_* descriptor in (valid/ready), start_o/base_addr_*_o and busy_i/y_i to/from
// top_pd, res_* result out (valid/ready), done_o/err_o end-of-job pulses.
module sa_job_sched
    import systolic_array_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int AW    = 6,
    parameter int TW    = 4,
    parameter int DRAIN = SCHED_DRAIN,
    parameter int TMO   = SCHED_TMO
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          job_valid_i,
    output logic          job_ready_o,
    input  logic [AW-1:0] job_base_x_i,
    input  logic [AW-1:0] job_base_w_i,
    input  logic [AW-1:0] job_stride_x_i,
    input  logic [AW-1:0] job_stride_w_i,
    input  logic [TW-1:0] job_ntiles_i,
    output logic          start_o,
    output logic [AW-1:0] base_addr_x_o,
    output logic [AW-1:0] base_addr_w_o,
    input  logic          busy_i,
    input  word_t         y_i [N],
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output word_t         res_data_o [N],
    output logic [TW-1:0] res_tile_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int WD_MAX = (TMO > SCHED_WAIT_HI) ? TMO : SCHED_WAIT_HI;
    localparam int CW     = $clog2(WD_MAX + 1);
    localparam int DW     = $clog2(DRAIN + 1);

    sched_state_t  r_state;
    logic          r_job_ready;
    logic          r_start;
    logic          r_done;
    logic          r_err;
    logic          r_res_valid;
    logic [AW-1:0] r_addr_x;
    logic [AW-1:0] r_addr_w;
    logic [AW-1:0] r_stride_x;
    logic [AW-1:0] r_stride_w;
    logic [TW-1:0] r_ntiles;
    logic [TW-1:0] r_t;
    logic [TW-1:0] r_res_tile;
    logic [DW-1:0] r_dcnt;
    word_t         r_res_data [N];

    logic          w_wd_clear;
    logic          w_wd_load;
    logic          w_wd_en;
    logic [CW-1:0] w_wd_limit;
    logic          w_wd_expired;

    // One watchdog serves both waits: armed with the short acknowledge window while
    // the start pulse is out, re-armed with TMO on the cycle busy is first seen.
    assign w_wd_clear = (r_state == S_IDLE);
    assign w_wd_load  = (r_state == S_ISSUE) || ((r_state == S_WAIT_HI) && busy_i);
    assign w_wd_en    = (r_state == S_WAIT_HI) || (r_state == S_RUN);
    assign w_wd_limit = (r_state == S_ISSUE) ? CW'(SCHED_WAIT_HI) : CW'(TMO);

    sa_watchdog #(.CW(CW)) u_wd (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_clear   (w_wd_clear),
        .i_load    (w_wd_load),
        .i_limit   (w_wd_limit),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            r_state     <= S_IDLE;
            r_job_ready <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_addr_x    <= '0;
            r_addr_w    <= '0;
            r_stride_x  <= '0;
            r_stride_w  <= '0;
            r_ntiles    <= '0;
            r_t         <= '0;
            r_res_tile  <= '0;
            r_dcnt      <= '0;
            r_res_data  <= '{default: '0};
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ready is held low for the first cycle out of reset.
                    if (!r_job_ready) begin
                        r_job_ready <= 1'b1;
                    end else if (job_valid_i) begin
                        r_job_ready <= 1'b0;
                        r_addr_x    <= job_base_x_i;
                        r_addr_w    <= job_base_w_i;
                        r_stride_x  <= job_stride_x_i;
                        r_stride_w  <= job_stride_w_i;
                        r_ntiles    <= job_ntiles_i;
                        r_t         <= '0;
                        if (job_ntiles_i == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: r_state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (busy_i) begin
                        r_state <= S_RUN;
                    end else if (w_wd_expired) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_ABORT;
                    end
                end
                S_RUN: begin
                    // A fall on the last allowed cycle still counts as completion.
                    if (!busy_i) begin
                        r_dcnt  <= '0;
                        r_state <= S_DRAIN;
                    end else if (w_wd_expired) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_ABORT;
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DW'(DRAIN - 1)) begin
                        r_res_data  <= y_i;
                        r_res_tile  <= r_t;
                        r_res_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready_i) begin
                        r_res_valid <= 1'b0;
                        if (r_t == r_ntiles - 1'b1) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            // Running sums replace base + t*stride; wrap is intended.
                            r_t      <= r_t + 1'b1;
                            r_addr_x <= r_addr_x + r_stride_x;
                            r_addr_w <= r_addr_w + r_stride_w;
                            r_start  <= 1'b1;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_FIN, S_ABORT: begin
                    r_job_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign job_ready_o   = r_job_ready;
    assign start_o       = r_start;
    assign base_addr_x_o = r_addr_x;
    assign base_addr_w_o = r_addr_w;
    assign res_valid_o   = r_res_valid;
    assign res_data_o    = r_res_data;
    assign res_tile_o    = r_res_tile;
    assign done_o        = r_done;
    assign err_o         = r_err;

endmodule

// File: doc/sa_job_sched.md
# sa_job_sched

Job-level scheduler that sequences the SPAD-fed systolic-array top (`top_pd`) over a run of tiles. It accepts a job descriptor (base addresses, per-tile strides, tile count) and issues one `start` pulse per tile with computed SPAD base addresses. For each tile it waits for the array to finish and drain, captures the N-lane result, and hands it downstream on a valid/ready port. A watchdog aborts the job if `top_pd` never responds.

## Interface
Parameters:
- `N`, 4: lanes / SA dimension; width of the result vector.
- `AW`, 6: SPAD address width.
- `TW`, 4: tile-count width; at most 2^TW−1 tiles per job.
- `DRAIN`, 2·N: cycles waited after `busy_i` falls before `y_i` is sampled.
- `TMO`, 64: watchdog limit, in cycles, for `busy_i` to fall.

Ports:
- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-high.
- `job_valid_i`  in  1  job descriptor valid.
- `job_ready_o`  out  1  scheduler idle; a job is accepted on `valid&ready`.
- `job_base_x_i`  in  AW  first X base address.
- `job_base_w_i`  in  AW  first W base address.
- `job_stride_x_i`  in  AW  X address increment per tile.
- `job_stride_w_i`  in  AW  W address increment per tile.
- `job_ntiles_i`  in  TW  tile count; 0 is legal.
- `start_o`  out  1  one-cycle start pulse to `top_pd`.
- `base_addr_x_o`  out  AW  X base address of the current tile, to `top_pd`.
- `base_addr_w_o`  out  AW  W base address of the current tile, to `top_pd`.
- `busy_i`  in  1  busy from `top_pd`.
- `y_i`  in  N×word_t  result vector from `top_pd`, unpacked.
- `res_valid_o`  out  1  captured result valid.
- `res_ready_i`  in  1  downstream ready.
- `res_data_o`  out  N×word_t  captured result, unpacked.
- `res_tile_o`  out  TW  index of the tile in `res_data_o`.
- `done_o`  out  1  one-cycle pulse at job end.
- `err_o`  out  1  one-cycle pulse together with `done_o` when the job is aborted.

## Operation
- FSM states:
  - `IDLE`: `job_ready_o`=1. On accept, latch the descriptor and set t=0. If ntiles=0 go to `FIN`, else go to `ISSUE`.
  - `ISSUE`: `start_o`=1 for one cycle → `WAIT_HI`.
  - `WAIT_HI`: wait for `busy_i`=1 → `RUN`. If it is not seen within 4 cycles → `ABORT`.
  - `RUN`: wait for `busy_i`=0 → `DRAIN`. If `TMO` cycles elapse first → `ABORT`.
  - `DRAIN`: count `DRAIN` cycles, then sample `y_i` into `res_data_o` and set `res_tile_o`=t → `EMIT`.
  - `EMIT`: `res_valid_o`=1. On `res_ready_i`, if t=ntiles−1 go to `FIN`, else t++ and go to `ISSUE`.
  - `FIN`: `done_o`=1 → `IDLE`.
  - `ABORT`: `done_o`=1 and `err_o`=1 → `IDLE`.
- Address generation:
  - `base_addr_x_o` = base_x + t·stride_x, mod 2^AW; wraps silently.
  - `base_addr_w_o` = base_w + t·stride_w, mod 2^AW; wraps silently.
  - Computed with a running accumulator (add stride on each t++), not a multiplier.
- `job_valid_i` is ignored outside `IDLE`. Descriptor inputs may change after acceptance.
- Reset mid-job: all state clears immediately. No further `start_o`; any pending result is dropped.

## Timing
- Reset values: every output is 0, including `job_ready_o`. `job_ready_o` rises in the first cycle after reset release.
- Accept at cycle T:
  - `start_o` high in cycle T+1 only (ntiles ≥ 1).
  - `base_addr_*_o` are valid in T+1 and stay stable until the next `ISSUE`.
- `RUN` exit: `busy_i` falls at cycle B. `DRAIN` occupies B+1 … B+DRAIN. `y_i` is sampled on the last `DRAIN` edge. `res_valid_o` is high from B+DRAIN+1.
- `EMIT` hold: `res_valid_o`, `res_data_o` and `res_tile_o` hold until handshake. `res_valid_o` does not drop without `res_ready_i`.
- Handshake at cycle H:
  - Next tile: `start_o` in H+1.
  - Last tile: `done_o` in H+1 and `job_ready_o` in H+2.
- ntiles=0: `done_o` in T+1, no `start_o`.
- `busy_i` already 1 in `ISSUE`: `WAIT_HI` exits on the first sampled 1.

## Structure
- Add to `systolic_array_pkg`:
  - `sched_state_t` enum.
  - Default constants `SCHED_DRAIN` and `SCHED_TMO`.
  - Reuse `word_t`.
- Sub-module `sa_watchdog`:
  - Loadable down-counter with `clear`, `en` and `expired` outputs.
  - One instance, shared by `WAIT_HI` (limit 4) and `RUN` (limit `TMO`).
- FSM, address accumulators and the result register stay in `sa_job_sched`.

## Test plan
- Reset:
  - Assert `n_rst` mid-`RUN` → all outputs 0 asynchronously.
  - After release → `job_ready_o`=1 next cycle, no `start_o`.
- Single tile:
  - Stimulus: base_x=8, base_w=16, ntiles=1; SPAD holds X=[1,2,3,4], W=[5,6,7,8]; real `top_pd`.
  - Response: one `start_o` with addrs 8/16; `res_data_o` matches the golden SA output; `res_tile_o`=0; `done_o`, no `err_o`.
- Multi-tile stride:
  - Stimulus: base_x=8, base_w=16, strides 4/4, ntiles=3.
  - Response: three starts with X addrs 8, 12, 16 and W addrs 16, 20, 24; `res_tile_o` 0, 1, 2 in order.
- Wrap and zero-length:
  - base_x=60, stride_x=4, ntiles=2 → X addrs 60, then 0.
  - ntiles=0 → `done_o` in T+1, no `start_o`.
- Backpressure: hold `res_ready_i`=0 for 10 cycles → `res_valid_o` and data stable, no new `start_o`, `start_o` in the cycle after the handshake.
- Watchdog:
  - `busy_i` stuck 0 → `err_o`+`done_o` 4 cycles after `WAIT_HI` entry.
  - `busy_i` stuck 1 → abort after `TMO` cycles.
  - In both cases the next job is accepted normally.
